// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU (ADD/SUB/logic/compare/shift/PASSB, optional MUL via ALU_MUL_EN) with flags and tag.
// Latency 2 cycles, 1 op/cycle; S1 registers operands, S2 registers result and flags.
// Backpressure: valid/ready; a stalled output holds stable, in_ready drops when both stages are full; flush empties both.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_illegal
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_PASSB = 4'd11;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL   = 4'd12;
`endif

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;
    logic             illegal;
  } s2_t;

  s1_t  s1_q;
  s2_t  s2_q;
  s2_t  s2_nxt;
  logic s1_valid;
  logic s2_valid;
  logic s1_load;
  logic s2_load;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SH_W-1:0]  shamt;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mul_lo;
`endif

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load || flush;

  always_comb begin
    is_sub = (s1_q.op == OP_SUB);
    // SUB reuses the adder as A + ~B + 1 so carry reads as "no borrow".
    b_eff  = is_sub ? ~s1_q.b : s1_q.b;
    sum    = {1'b0, s1_q.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    shamt  = s1_q.b[SH_W-1:0];
`ifdef ALU_MUL_EN
    mul_lo = s1_q.a * s1_q.b;
`endif

    s2_nxt     = '0;
    s2_nxt.tag = s1_q.tag;
    case (s1_q.op)
      OP_ADD, OP_SUB: begin
        s2_nxt.result = sum[WIDTH-1:0];
        s2_nxt.carry  = sum[WIDTH];
        s2_nxt.ovf    = (s1_q.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                        (sum[WIDTH-1] != s1_q.a[WIDTH-1]);
      end
      OP_AND:   s2_nxt.result = s1_q.a & s1_q.b;
      OP_OR:    s2_nxt.result = s1_q.a | s1_q.b;
      OP_XOR:   s2_nxt.result = s1_q.a ^ s1_q.b;
      OP_NOR:   s2_nxt.result = ~(s1_q.a | s1_q.b);
      OP_SLT:   s2_nxt.result = {{(WIDTH-1){1'b0}}, ($signed(s1_q.a) < $signed(s1_q.b))};
      OP_SLTU:  s2_nxt.result = {{(WIDTH-1){1'b0}}, (s1_q.a < s1_q.b)};
      OP_SLL:   s2_nxt.result = s1_q.a << shamt;
      OP_SRL:   s2_nxt.result = s1_q.a >> shamt;
      OP_SRA:   s2_nxt.result = $signed(s1_q.a) >>> shamt;
      OP_PASSB: s2_nxt.result = s1_q.b;
`ifdef ALU_MUL_EN
      OP_MUL:   s2_nxt.result = mul_lo;
`endif
      default:  s2_nxt.illegal = 1'b1;
    endcase
    s2_nxt.zero = (s2_nxt.result == '0);
    s2_nxt.neg  = s2_nxt.result[WIDTH-1];
  end

  // Data registers only load with a valid op so idle outputs stay at their reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_q <= s2_nxt;
      end
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= '{op: in_op, a: in_a, b: in_b, tag: in_tag};
      end
    end
  end

  assign out_valid   = s2_valid;
  assign out_result  = s2_q.result;
  assign out_tag     = s2_q.tag;
  assign out_zero    = s2_q.zero;
  assign out_neg     = s2_q.neg;
  assign out_carry   = s2_q.carry;
  assign out_ovf     = s2_q.ovf;
  assign out_illegal = s2_q.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: expectations queued at input handshake, compared at output handshake.
module tb_alu_pipe;

  localparam int W = 32;
  localparam int T = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_op = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [T-1:0] in_tag = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic [T-1:0] out_tag;
  logic         out_zero, out_neg, out_carry, out_ovf, out_illegal;

  typedef struct packed {
    logic [W-1:0] res;
    logic [T-1:0] tag;
    logic z, n, c, v, ill;
  } exp_t;

  exp_t sb[$];
  exp_t seen[$];
  int   checks = 0;
  int   errors = 0;
  bit   rnd = 1'b0;
  bit   hold_prev = 1'b0;
  exp_t prev;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .TAG_W(T)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_zero(out_zero),
    .out_neg(out_neg), .out_carry(out_carry), .out_ovf(out_ovf),
    .out_illegal(out_illegal)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [T-1:0] tag);
    exp_t   e;
    longint sa, sb_, wide;
    e = '0;
    e.tag = tag;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (op)
      4'd0: begin
        wide  = longint'({32'b0, a}) + longint'({32'b0, b});
        e.res = wide[W-1:0];
        e.c   = (wide > 64'sh0FFFF_FFFF);
        e.v   = ((sa + sb_) > 64'sh7FFF_FFFF) || ((sa + sb_) < -64'sh8000_0000);
      end
      4'd1: begin
        e.res = a - b;
        e.c   = (a >= b);
        e.v   = ((sa - sb_) > 64'sh7FFF_FFFF) || ((sa - sb_) < -64'sh8000_0000);
      end
      4'd2:  e.res = a & b;
      4'd3:  e.res = a | b;
      4'd4:  e.res = a ^ b;
      4'd5:  e.res = ~(a | b);
      4'd6:  e.res = (sa < sb_) ? 32'd1 : 32'd0;
      4'd7:  e.res = (a < b) ? 32'd1 : 32'd0;
      4'd8:  e.res = a << b[4:0];
      4'd9:  e.res = a >> b[4:0];
      4'd10: e.res = (sa >>> b[4:0]);
      4'd11: e.res = b;
`ifdef ALU_MUL_EN
      4'd12: e.res = a * b;
`endif
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 0);
    e.n = e.res[W-1];
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t cur, e;
    cur = '{res: out_result, tag: out_tag, z: out_zero, n: out_neg,
            c: out_carry, v: out_ovf, ill: out_illegal};
    if (!rst_n) begin
      sb.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_out", 64'(cur), 64'(prev));
      end
      if (flush) begin
        sb.delete();
        hold_prev = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) check("unexpected_out", 64'd1, 64'd0);
          else begin
            e = sb.pop_front();
            check("sb_result", 64'(cur.res), 64'(e.res));
            check("sb_tag", 64'(cur.tag), 64'(e.tag));
            check("sb_flags", 64'({cur.z, cur.n, cur.c, cur.v, cur.ill}),
                  64'({e.z, e.n, e.c, e.v, e.ill}));
          end
          seen.push_back(cur);
        end
        if (in_valid && in_ready) sb.push_back(model(in_op, in_a, in_b, in_tag));
        hold_prev = out_valid && !out_ready;
        prev = cur;
      end
    end
  end

  // Returns #1 after the edge that accepted the op.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [T-1:0] tag);
    bit acc = 1'b0;
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk); #1;
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 30 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_left", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int base;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_outputs", 64'({out_valid, out_result, out_tag, out_zero, out_neg,
                               out_carry, out_ovf, out_illegal}), 64'd0);

    // ADD overflow and two-cycle latency
    send(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd3);
    check("lat_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_valid", 64'(out_valid), 64'd1);
    check("add_result", 64'(out_result), 64'h8000_0000);
    check("add_flags", 64'({out_ovf, out_neg, out_carry, out_zero}), 64'b1100);
    check("add_tag", 64'(out_tag), 64'd3);

    // SUB then SLT back-to-back
    send(4'd1, 32'd5, 32'd5, 5'd1);
    send(4'd6, 32'hFFFF_FFFF, 32'd1, 5'd2);
    check("sub_valid", 64'(out_valid), 64'd1);
    check("sub_result", 64'(out_result), 64'd0);
    check("sub_zc", 64'({out_zero, out_carry}), 64'b11);
    @(posedge clk); #1;
    check("slt_valid", 64'(out_valid), 64'd1);
    check("slt_result", 64'(out_result), 64'd1);
    check("slt_tag", 64'(out_tag), 64'd2);
    drain();

    // Stall with four ops
    out_ready = 1'b0;
    base = seen.size();
    send(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd10);
    send(4'd3, 32'h1234_0000, 32'h0000_5678, 5'd11);
    in_op = 4'd4; in_a = 32'hAAAA_AAAA; in_b = 32'hFFFF_FFFF; in_tag = 5'd12; in_valid = 1'b1;
    @(negedge clk);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'd4, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 5'd12);
    send(4'd5, 32'd0, 32'd0, 5'd13);
    drain();
    check("stall_count", 64'(seen.size() - base), 64'd4);
    if (seen.size() - base == 4) begin
      check("stall_order0", 64'(seen[base].tag), 64'd10);
      check("stall_res3", 64'(seen[base+3].res), 64'hFFFF_FFFF);
    end

    // Shifts
    base = seen.size();
    send(4'd10, 32'h8000_0000, 32'h24, 5'd4);
    send(4'd8, 32'd1, 32'd31, 5'd5);
    drain();
    if (seen.size() - base == 2) begin
      check("sra_result", 64'(seen[base].res), 64'hF800_0000);
      check("sll_result", 64'(seen[base+1].res), 64'h8000_0000);
    end else check("shift_count", 64'(seen.size() - base), 64'd2);

    // Flush with two in flight plus a new op
    base = seen.size();
    send(4'd11, 32'd0, 32'd77, 5'd20);
    send(4'd11, 32'd0, 32'd78, 5'd21);
    in_op = 4'd11; in_b = 32'd79; in_tag = 5'd22; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    repeat (5) @(posedge clk);
    #1 check("flush_none_out", 64'(seen.size() - base), 64'd0);

    // MUL / illegal ops
    base = seen.size();
    send(4'd12, 32'd6, 32'd7, 5'd6);
    send(4'd15, 32'd9, 32'd9, 5'd7);
    drain();
    if (seen.size() - base == 2) begin
`ifdef ALU_MUL_EN
      check("mul_result", 64'(seen[base].res), 64'd42);
      check("mul_illegal", 64'(seen[base].ill), 64'd0);
`else
      check("mul_result", 64'(seen[base].res), 64'd0);
      check("mul_illegal", 64'(seen[base].ill), 64'd1);
`endif
      check("op15_illegal", 64'({seen[base+1].ill, seen[base+1].z, seen[base+1].res}),
            64'({1'b1, 1'b1, 32'd0}));
    end else check("mul_count", 64'(seen.size() - base), 64'd2);

    // Randomised stream with random backpressure
    rnd = 1'b1;
    for (int i = 0; i < 60; i++)
      send(4'($urandom_range(0, 15)), $urandom, $urandom, 5'(i));
    rnd = 1'b0;
    drain();

    // Reset mid-stream
    send(4'd0, 32'd1, 32'd2, 5'd1);
    send(4'd0, 32'd3, 32'd4, 5'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_ready", 64'(in_ready), 64'd1);
    check("rst_mid_result", 64'(out_result), 64'd0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("rst_after_valid", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
